// File: rtl/adder_pkg.sv
// Shared constants and the lookahead carry helper
// used by the adder32 top and its cla_group slices.
package adder_pkg;

   localparam int ADDER_WIDTH = 32;
   localparam int CLA_GROUP   = 4;
   localparam int LA_MAX      = 64;

   // Carry into position n as a flat sum-of-products.
   // The result is never a ripple through positions 0..n-1.
   function automatic logic la_carry(
      input logic [LA_MAX-1:0] g,
      input logic [LA_MAX-1:0] p,
      input logic              c0,
      input int                n
   );
      logic c;
      logic t;
      c = c0;
      for (int k = 0; k < n; k++) begin
         c = c & p[k];
      end
      for (int i = 0; i < n; i++) begin
         t = g[i];
         for (int k = i + 1; k < n; k++) begin
            t = t & p[k];
         end
         c = c | t;
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: local sum
// plus group generate/propagate for the upper level.
module cla_group
   import adder_pkg::*;
#(
   parameter int GROUP = CLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             g,
   output logic             p
);

   logic [GROUP-1:0] gb;
   logic [GROUP-1:0] pb;
   logic [GROUP-1:0] c;

   assign gb = a & b;
   assign pb = a ^ b;

   always_comb begin
      c = '0;
      for (int j = 0; j < GROUP; j++) begin
         c[j] = la_carry(LA_MAX'(gb), LA_MAX'(pb), cin, j);
      end
   end

   assign sum = pb ^ c;
   assign g   = la_carry(LA_MAX'(gb), LA_MAX'(pb), 1'b0, GROUP);
   assign p   = &pb;

endmodule

// File: rtl/adder32.sv
// Two-level carry-lookahead adder with combinational
// result/flags and a one-cycle registered copy.
module adder32
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q
);

   localparam int NG = WIDTH / GROUP;

   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG:0]      grp_c;
   logic             c_msb;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   for (genvar i = 0; i < NG; i++) begin : g_grp
      cla_group #(
         .GROUP(GROUP)
      ) u_grp (
         .a   (a[i*GROUP +: GROUP]),
         .b   (b[i*GROUP +: GROUP]),
         .cin (grp_c[i]),
         .sum (sum[i*GROUP +: GROUP]),
         .g   (grp_g[i]),
         .p   (grp_p[i])
      );
   end

   always_comb begin
      grp_c = '0;
      for (int j = 0; j <= NG; j++) begin
         grp_c[j] = la_carry(LA_MAX'(grp_g), LA_MAX'(grp_p), cin, j);
      end
   end

   // Carry into the MSB falls out of that bit's sum.
   assign c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
   assign cout  = grp_c[NG];
   assign ovf   = c_msb ^ cout;

   always_comb begin
      sum_d  = sum;
      cout_d = cout;
      ovf_d  = ovf;
      if (rst) begin
         sum_d  = '0;
         cout_d = 1'b0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
   end

endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: checks the combinational
// outputs directly and the registered ones a cycle later.
module tb_adder32;
   import adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic        cin;
   logic [31:0] sum, sum_q;
   logic        cout, ovf, cout_q, ovf_q;

   int n_chk  = 0;
   int n_pass = 0;

   logic [33:0] sb[$];
   logic [33:0] last;

   adder32 dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   function automatic logic [33:0] model(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic c);
      logic [32:0] r;
      logic        o;
      r = {1'b0, x} + {1'b0, y} + {32'd0, c};
      o = (x[31] == y[31]) && (r[31] != x[31]);
      return {o, r};
   endfunction

   task automatic check_comb();
      logic [33:0] e;
      e = model(a, b, cin);
      check("sum", sum, e[31:0]);
      check("cout", 32'(cout), 32'(e[32]));
      check("ovf", 32'(ovf), 32'(e[33]));
   endtask

   task automatic step(input logic [31:0] ta,
                       input logic [31:0] tb_,
                       input logic tc,
                       input logic tr);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; rst = tr;
      #1;
      check_comb();
      sb.push_back(tr ? 34'd0 : model(ta, tb_, tc));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         last = sb.pop_front();
         check("sum_q", sum_q, last[31:0]);
         check("cout_q", 32'(cout_q), 32'(last[32]));
         check("ovf_q", 32'(ovf_q), 32'(last[33]));
      end
   endtask

   task automatic disturb(input logic [31:0] ta,
                          input logic [31:0] tb_);
      #2;
      a = ta; b = tb_; cin = 1'b1;
      #1;
      check_comb();
      check("hold_sum_q", sum_q, last[31:0]);
      check("hold_cout_q", 32'(cout_q), 32'(last[32]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] xa, xb;
      a = '0; b = '0; cin = 1'b0; rst = 1'b1;

      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      check("rst_sum", sum, 32'hFFFF_FFFE);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("post_rst_sum_q", sum_q, 32'hFFFF_FFFE);
      check("post_rst_cout_q", 32'(cout_q), 32'd1);

      step(32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0);
      check("lit_sum_q", sum_q, 32'h0000_000F);
      step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      check("wrap_sum_q", sum_q, 32'h0);
      check("wrap_cout_q", 32'(cout_q), 32'd1);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("ones_sum_q", sum_q, 32'hFFFF_FFFF);
      step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      check("ovf_sum_q", sum_q, 32'h8000_0000);
      check("ovf_q_lit", 32'(ovf_q), 32'd1);
      step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      check("negovf_q", 32'(ovf_q), 32'd1);

      disturb(32'h1234_5678, 32'h0FED_CBA9);

      // Reset mid-stream, then resume on the first clean edge.
      step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
      step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      check("resume_sum_q", sum_q, 32'h2345_678A);

      xa = 32'h1FFF_FFFF;
      xb = 32'h2000_000E;
      step(xa, xb, 1'b0, 1'b0);
      check("walk0_sum_q", sum_q, 32'h4000_000D);
      for (int i = 0; i < 140; i++) begin
         xa = xa + 32'h1FFF_FFFF;
         xb = xb + 32'h1FFF_FFFF;
         step(xa, xb, 1'b0, 1'b0);
      end

      for (int i = 0; i < 60; i++) begin
         step($urandom, $urandom, 1'($urandom_range(1)), 1'b0);
         if (i % 10 == 0) disturb($urandom, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adder32.md
ADDER32 -- requirements
Module: adder32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are multiples of 4 (≥4).
REQ-002 The block SHALL have parameter GROUP, default 4, giving the carry-lookahead group width; WIDTH SHALL be a multiple of GROUP.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, unsigned or two's-complement.
REQ-006 The block SHALL have port b  input  WIDTH  operand B.
REQ-007 The block SHALL have port cin  input  1  carry-in.
REQ-008 The block SHALL have port sum  output  WIDTH  combinational (a+b+cin) mod 2^WIDTH.
REQ-009 The block SHALL have port cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
REQ-010 The block SHALL have port ovf  output  1  combinational signed overflow: operand MSBs equal and sum MSB differs.
REQ-011 The block SHALL have port sum_q  output  WIDTH  registered sum.
REQ-012 The block SHALL have port cout_q  output  1  registered cout.
REQ-013 The block SHALL have port ovf_q  output  1  registered ovf.

Function
REQ-014 sum, cout and ovf SHALL be purely combinational, with zero cycles of latency and no dependence on clk or rst.
REQ-015 For known (non-X) a, b and cin, sum and cout SHALL never be X/Z, so that a 4-state identity compare (===) with a+b+cin always passes.
REQ-016 The carry chain SHALL be carry-lookahead: each GROUP slice produces generate/propagate; a second lookahead level combines the group G/P into the group carries.
REQ-017 Wrap-around: a result ≥ 2^WIDTH SHALL set cout=1, with sum holding the low WIDTH bits.
REQ-018 cin=1 with a=b=all-ones SHALL give sum=all-ones and cout=1.
REQ-019 ovf SHALL be computed as carry-into-MSB XOR carry-out-of-MSB.
REQ-020 On each rising clk edge with rst=0, sum_q/cout_q/ovf_q SHALL load the current sum/cout/ovf (one-cycle latency).
REQ-021 Input changes between clock edges SHALL affect only the combinational outputs, never the registered outputs.

Reset
REQ-022 On a rising clk edge with rst=1, sum_q, cout_q and ovf_q SHALL become 0, overriding any new inputs.
REQ-023 Reset SHALL NOT affect the combinational outputs, which track a, b and cin during reset.
REQ-024 Deasserting rst mid-stream SHALL make the registered outputs load the inputs at the first edge with rst=0.

Structure
REQ-025 Constants ADDER_WIDTH=32 and CLA_GROUP=4 SHALL reside in a shared package, adder_pkg.
REQ-026 One sub-module, cla_group, SHALL be used: a GROUP-bit lookahead slice with inputs a, b and cin and outputs sum, G and P, instantiated WIDTH/GROUP times via generate.
REQ-027 The top level SHALL contain only the second-level lookahead, the ovf logic and the output register.

Verification
REQ-028 a=0x00000000, b=0x0000000F, cin=0 -> sum=0x0000000F, cout=0, ovf=0; after the next edge, sum_q=0x0000000F.
REQ-029 a=0x1FFFFFFF, b=0x2000000E, cin=0 -> sum=0x4000000D, cout=0; stepping a and b by +0x1FFFFFFF per cycle for 140 cycles -> every cycle sum===a+b (mod 2^32).
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0.
REQ-031 a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1; a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, ovf=1.
REQ-032 With rst=1 for two edges and a=b=0xFFFFFFFF -> sum_q=0, cout_q=0, ovf_q=0 while sum=0xFFFFFFFE; then rst=0 -> the next edge gives sum_q=0xFFFFFFFE, cout_q=1.
